spi_master_param: RTL and testbench

//  Parametrised full-duplex SPI master. Generalises the fixed 16-bit, 2-slave master:
//  - configurable word width, chip-select count and SCLK divider
//  - all four SPI modes (CPOL/CPHA), latched per transfer
//  - start/busy/done handshake, MISO word returned on rx_data

---
 rtl/spi_master_param.sv | 153 +++++++++++++++
 tb/tb_spi_master_param.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: configurable word width, chip-select count and SCLK
// divider, all four CPOL/CPHA modes, start/busy/done handshake. All outputs are registered.
module spi_master_param #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned N_CS    = 2,
  parameter int unsigned CLK_DIV = 4,
  localparam int unsigned SEL_W  = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [N_CS-1:0]   cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EdgeW = $clog2(2 * DATA_W);
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * DATA_W - 1);
  localparam logic [SEL_W:0]   NcsLim   = (SEL_W + 1)'(N_CS);

  typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [EdgeW-1:0]    edge_q, edge_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DATA_W-1:0]   tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [N_CS-1:0]     cs_n_q, cs_n_d;
  logic                div_end, lead, sel_ok;

  always_comb begin
    state_d   = state_q;
    div_d     = div_end ? '0 : div_q + 1'b1;
    edge_d    = edge_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    div_end   = (div_q == DivLast);
    // Even edge index is the leading edge (away from CPOL), odd is trailing.
    lead      = ~edge_q[0];
    sel_ok    = ({1'b0, cs_sel} < NcsLim);

    unique case (state_q)
      StIdle: begin
        div_d  = '0;
        edge_d = '0;
        cs_n_d = '1;
        sclk_d = cpol;
        busy_d = 1'b0;
        if (start && sel_ok) begin
          state_d = StSetup;
          busy_d  = 1'b1;
          cs_n_d  = ~(N_CS'(1) << cs_sel);
          cpol_d  = cpol;
          cpha_d  = cpha;
          rx_d    = '0;
          if (!cpha) begin
            mosi_d = tx_data[DATA_W-1];
            tx_d   = tx_data << 1;
          end else begin
            tx_d   = tx_data;
          end
        end
      end
      StSetup: begin
        if (div_end) state_d = StXfer;
      end
      StXfer: begin
        if (div_end) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (lead != cpha_q) rx_d = {rx_q[DATA_W-2:0], miso};
          if (cpha_q ? lead : (!lead && edge_q != EdgeLast)) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end
          if (edge_q == EdgeLast) begin
            edge_d  = '0;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (div_end) begin
          state_d   = StIdle;
          cs_n_d    = '1;
          rx_data_d = rx_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      edge_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: a 16-bit/2-CS/div-4 instance and an 8-bit/3-CS/div-1 instance,
// each with a pin-level SPI slave model; results checked against word-level expectations.
module tb_spi_master_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 1'b0, a_cpol = 1'b0, a_cpha = 1'b0, a_miso = 1'b0;
  logic [0:0]  a_sel = '0;
  logic [15:0] a_tx = '0;
  logic        a_sclk, a_mosi, a_busy, a_done;
  logic [1:0]  a_cs_n;
  logic [15:0] a_rx;

  logic        b_start = 1'b0, b_cpol = 1'b0, b_cpha = 1'b0, b_miso = 1'b0;
  logic [1:0]  b_sel = '0;
  logic [7:0]  b_tx = '0;
  logic        b_sclk, b_mosi, b_busy, b_done;
  logic [2:0]  b_cs_n;
  logic [7:0]  b_rx;

  int compared = 0;
  int mismatched = 0;

  spi_master_param #(.DATA_W(16), .N_CS(2), .CLK_DIV(4)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .cs_sel(a_sel), .cpol(a_cpol), .cpha(a_cpha),
    .tx_data(a_tx), .miso(a_miso), .sclk(a_sclk), .mosi(a_mosi), .cs_n(a_cs_n),
    .busy(a_busy), .done(a_done), .rx_data(a_rx)
  );

  spi_master_param #(.DATA_W(8), .N_CS(3), .CLK_DIV(1)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .cs_sel(b_sel), .cpol(b_cpol), .cpha(b_cpha),
    .tx_data(b_tx), .miso(b_miso), .sclk(b_sclk), .mosi(b_mosi), .cs_n(b_cs_n),
    .busy(b_busy), .done(b_done), .rx_data(b_rx)
  );

  // Slave model state, index 0 for instance a, 1 for instance b.
  logic [15:0] s_word[2];
  logic        s_cpol[2], s_cpha[2];
  logic [15:0] cap[2];
  int          rises[2], edges[2], drv[2];

  task automatic slave_start(input int i, input int w, output logic m);
    edges[i] = 0; drv[i] = 0; rises[i] = 0; cap[i] = '0;
    m = s_cpha[i] ? 1'b0 : s_word[i][w-1];
  endtask

  task automatic slave_edge(input int i, input int w, input logic sc, input logic mo,
                            input logic cur, output logic nxt);
    logic ld;
    int k;
    ld = (sc != s_cpol[i]);
    nxt = cur;
    edges[i]++;
    if (sc) rises[i]++;
    if (ld != s_cpha[i]) cap[i] = {cap[i][14:0], mo};
    else begin
      k = s_cpha[i] ? drv[i] : drv[i] + 1;
      drv[i]++;
      if (k < w) nxt = s_word[i][w-1-k];
    end
  endtask

  logic a_cs_act, b_cs_act;
  assign a_cs_act = ~&a_cs_n;
  assign b_cs_act = ~&b_cs_n;

  always @(posedge a_cs_act) slave_start(0, 16, a_miso);
  always @(posedge b_cs_act) slave_start(1, 8, b_miso);
  always @(a_sclk) if (a_cs_act === 1'b1) slave_edge(0, 16, a_sclk, a_mosi, a_miso, a_miso);
  always @(b_sclk) if (b_cs_act === 1'b1) slave_edge(1, 8, b_sclk, b_mosi, b_miso, b_miso);

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({a_cs_n, a_sclk, a_mosi, a_busy, a_done} !== 6'b110000 || a_rx !== '0) begin
      mismatched++;
      $display("FAIL reset_a: cs_n=%b sclk=%b mosi=%b busy=%b done=%b rx=%h, want 11/0/0/0/0/0",
               a_cs_n, a_sclk, a_mosi, a_busy, a_done, a_rx);
    end
    compared++;
    if ({b_cs_n, b_sclk, b_mosi, b_busy, b_done} !== 7'b1110000 || b_rx !== '0) begin
      mismatched++;
      $display("FAIL reset_b: cs_n=%b sclk=%b mosi=%b busy=%b done=%b rx=%h, want 111/0/0/0/0/0",
               b_cs_n, b_sclk, b_mosi, b_busy, b_done, b_rx);
    end
    reset = 1'b0;
  endtask

  // One transfer on instance a; optional re-pulse of start with altered ports mid-transfer.
  task automatic xfer_a(input string tag, input logic [0:0] sel, input logic pol, input logic pha,
                        input logic [15:0] tx, input logic [15:0] sw, input bit repulse);
    int n, lat, extra;
    logic [1:0] exp_cs;
    bit cs_ok;
    lat = 4 * (2 * 16 + 2);
    exp_cs = ~(2'b01 << sel);
    s_word[0] = sw; s_cpol[0] = pol; s_cpha[0] = pha;
    a_sel = sel; a_cpol = pol; a_cpha = pha; a_tx = tx;
    @(posedge clk); #1;
    compared++;
    if (a_sclk !== pol) begin
      mismatched++; $display("FAIL %s idle_sclk: got %b want %b", tag, a_sclk, pol);
    end
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    compared++;
    if (a_busy !== 1'b1 || a_cs_n !== exp_cs) begin
      mismatched++;
      $display("FAIL %s accept: busy=%b cs_n=%b want 1 %b", tag, a_busy, a_cs_n, exp_cs);
    end
    n = 0; cs_ok = 1'b1;
    while (n < lat + 20 && a_done !== 1'b1) begin
      if (repulse && n == 40) begin
        a_start = 1'b1; a_tx = 16'h1234; a_cpol = ~pol; a_cpha = ~pha; a_sel = ~sel;
      end
      if (repulse && n == 41) a_start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (a_done !== 1'b1 && (a_cs_n !== exp_cs || a_busy !== 1'b1)) cs_ok = 1'b0;
    end
    a_cpol = pol; a_cpha = pha; a_sel = sel; a_tx = tx;
    compared++;
    if (n != lat) begin
      mismatched++; $display("FAIL %s latency: got %0d want %0d", tag, n, lat);
    end
    compared++;
    if (a_rx !== sw || cap[0] !== tx) begin
      mismatched++;
      $display("FAIL %s data: rx=%h mosi_word=%h want rx=%h mosi_word=%h", tag, a_rx, cap[0], sw, tx);
    end
    compared++;
    if (rises[0] != 16 || a_cs_n !== 2'b11 || a_busy !== 1'b0 || !cs_ok) begin
      mismatched++;
      $display("FAIL %s framing: rises=%0d cs_n=%b busy=%b cs_stable=%b want 16 11 0 1",
               tag, rises[0], a_cs_n, a_busy, cs_ok);
    end
    if (repulse) begin
      extra = 0;
      repeat (lat + 20) begin
        @(posedge clk); #1;
        if (a_done === 1'b1 || a_busy === 1'b1) extra++;
      end
      compared++;
      if (extra != 0) begin
        mismatched++; $display("FAIL %s extra_done: got %0d active cycles want 0", tag, extra);
      end
    end
  endtask

  task automatic xfer_b(input string tag, input logic [1:0] sel, input logic pol, input logic pha,
                        input logic [7:0] tx, input logic [7:0] sw);
    int n, lat;
    lat = 1 * (2 * 8 + 2);
    s_word[1] = {8'h00, sw}; s_cpol[1] = pol; s_cpha[1] = pha;
    b_sel = sel; b_cpol = pol; b_cpha = pha; b_tx = tx;
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    compared++;
    if (b_cs_n !== ~(3'b001 << sel)) begin
      mismatched++; $display("FAIL %s cs: got %b want %b", tag, b_cs_n, ~(3'b001 << sel));
    end
    n = 0;
    while (n < lat + 10 && b_done !== 1'b1) begin
      @(posedge clk); #1; n++;
    end
    compared++;
    if (n != lat || b_rx !== sw || cap[1][7:0] !== tx) begin
      mismatched++;
      $display("FAIL %s xfer: lat=%0d rx=%h mosi_word=%h want %0d %h %h",
               tag, n, b_rx, cap[1][7:0], lat, sw, tx);
    end
  endtask

  task automatic test_mode0;
    xfer_a("mode0", 1'b0, 1'b0, 1'b0, 16'hA55A, 16'h3C3C, 1'b0);
  endtask

  task automatic test_mode3;
    xfer_a("mode3", 1'b1, 1'b1, 1'b1, 16'h8001, 16'hFFFF, 1'b0);
  endtask

  task automatic test_start_while_busy;
    xfer_a("busy_start", 1'b0, 1'b0, 1'b0, 16'hA55A, 16'h5AA5, 1'b1);
  endtask

  task automatic test_reset_mid;
    int n;
    s_word[0] = 16'h0F0F; s_cpol[0] = 1'b0; s_cpha[0] = 1'b0;
    a_sel = 1'b0; a_cpol = 1'b0; a_cpha = 1'b0; a_tx = 16'hF00D;
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    n = 0;
    while (n < 200 && edges[0] < 7) begin
      @(posedge clk); #1; n++;
    end
    compared++;
    if (n >= 200) begin
      mismatched++; $display("FAIL reset_mid wait: edges=%0d want 7", edges[0]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (a_cs_n !== 2'b11 || a_sclk !== 1'b0 || a_busy !== 1'b0 || a_rx !== '0 || a_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid: cs_n=%b sclk=%b busy=%b rx=%h done=%b want 11 0 0 0000 0",
               a_cs_n, a_sclk, a_busy, a_rx, a_done);
    end
    reset = 1'b0;
    xfer_a("after_reset", 1'b1, 1'b0, 1'b1, 16'hC0DE, 16'h1357, 1'b0);
  endtask

  task automatic test_bad_sel;
    int bad;
    bad = 0;
    b_sel = 2'd3; b_start = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (b_busy !== 1'b0 || b_cs_n !== 3'b111 || b_done !== 1'b0) bad++;
    end
    b_start = 1'b0;
    compared++;
    if (bad != 0) begin
      mismatched++; $display("FAIL bad_sel: %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int n1, n2, lat;
    logic [7:0] w1, w2;
    lat = 1 * (2 * 8 + 2);
    w1 = 8'($urandom); w2 = 8'($urandom);
    s_word[1] = {8'h00, w1}; s_cpol[1] = 1'b0; s_cpha[1] = 1'b1;
    b_cpol = 1'b0; b_cpha = 1'b1; b_sel = 2'd2; b_tx = 8'hC3;
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    n1 = 0;
    while (n1 < lat + 10 && b_done !== 1'b1) begin
      @(posedge clk); #1; n1++;
    end
    compared++;
    if (n1 != lat || b_rx !== w1 || cap[1][7:0] !== 8'hC3 || b_cs_n !== 3'b111) begin
      mismatched++;
      $display("FAIL b2b_first: lat=%0d rx=%h mosi_word=%h cs_n=%b want %0d %h c3 111",
               n1, b_rx, cap[1][7:0], b_cs_n, lat, w1);
    end
    // Start raised in the done cycle itself.
    s_word[1] = {8'h00, w2}; b_tx = 8'h5A; b_sel = 2'd0; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    compared++;
    if (b_cs_n !== 3'b110 || b_busy !== 1'b1) begin
      mismatched++; $display("FAIL b2b_gap: cs_n=%b busy=%b want 110 1", b_cs_n, b_busy);
    end
    n2 = 0;
    while (n2 < lat + 10 && b_done !== 1'b1) begin
      @(posedge clk); #1; n2++;
    end
    compared++;
    if (n2 + 1 != lat + 1 || b_rx !== w2 || cap[1][7:0] !== 8'h5A) begin
      mismatched++;
      $display("FAIL b2b_second: done_spacing=%0d rx=%h mosi_word=%h want %0d %h 5a",
               n2 + 1, b_rx, cap[1][7:0], lat + 1, w2);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      xfer_a("rand_a", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b0);
    end
    for (int it = 0; it < 4; it++) begin
      xfer_b("rand_b", 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_start_while_busy();
    test_reset_mid();
    test_bad_sel();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
